// File: rtl/ysyx_25010008_lsu_pkg.sv
// Shared types for the LSU AXI master: FSM states, access sizes and completion codes.
package ysyx_25010008_lsu_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RADDR,
        S_RDATA,
        S_WRITE,
        S_BRESP,
        S_DONE
    } lsu_state_e;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2,
        SZ_D = 2'd3
    } lsu_size_e;

    typedef enum logic [1:0] {
        ERR_OK       = 2'd0,
        ERR_BUS      = 2'd1,
        ERR_MISALIGN = 2'd2,
        ERR_TIMEOUT  = 2'd3
    } lsu_err_e;

    // Doubleword accesses are only legal when the bus is 64 bits wide.
    function automatic logic is_misaligned(input logic [2:0] addr_lo,
                                           input logic [1:0] size,
                                           input logic       wide);
        case (size)
            SZ_B:    return 1'b0;
            SZ_H:    return addr_lo[0];
            SZ_W:    return |addr_lo[1:0];
            default: return !wide || (|addr_lo);
        endcase
    endfunction

endpackage

// File: rtl/ysyx_25010008_lsu_axi_if.sv
// AXI-lite style read/write channel bundle between the LSU (master) and memory (slave).
interface ysyx_25010008_lsu_axi_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    logic                  arvalid;
    logic                  arready;
    logic [ADDR_W-1:0]     araddr;
    logic                  rvalid;
    logic                  rready;
    logic [DATA_W-1:0]     rdata_bus;
    logic [1:0]            rresp;
    logic                  awvalid;
    logic                  awready;
    logic [ADDR_W-1:0]     awaddr;
    logic                  wvalid;
    logic                  wready;
    logic [DATA_W-1:0]     wdata;
    logic [DATA_W/8-1:0]   wstrb;
    logic                  bvalid;
    logic                  bready;
    logic [1:0]            bresp;

    modport master (
        output arvalid, araddr, rready, awvalid, awaddr, wvalid, wdata, wstrb, bready,
        input  arready, rvalid, rdata_bus, rresp, awready, wready, bvalid, bresp
    );

    modport slave (
        input  arvalid, araddr, rready, awvalid, awaddr, wvalid, wdata, wstrb, bready,
        output arready, rvalid, rdata_bus, rresp, awready, wready, bvalid, bresp
    );

endinterface

// File: rtl/ysyx_25010008_lsu_align.sv
// Byte-lane steering: store strobe/data shift and load shift with sign/zero extension.
module ysyx_25010008_lsu_align
    import ysyx_25010008_lsu_pkg::*;
#(
    parameter  int unsigned DATA_W = 32,
    localparam int unsigned STRB_W = DATA_W / 8,
    localparam int unsigned OFF_W  = $clog2(STRB_W)
) (
    input  logic [OFF_W-1:0]  off_i,
    input  logic [1:0]        size_i,
    input  logic              sext_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [DATA_W-1:0] rdata_i,
    output logic [STRB_W-1:0] wstrb_o,
    output logic [DATA_W-1:0] wdata_o,
    output logic [DATA_W-1:0] load_o
);

    logic [7:0]        mask8;
    logic [DATA_W-1:0] shifted;

    always_comb begin
        case (size_i)
            SZ_B:    mask8 = 8'h01;
            SZ_H:    mask8 = 8'h03;
            SZ_W:    mask8 = 8'h0F;
            default: mask8 = 8'hFF;
        endcase
        wstrb_o = mask8[STRB_W-1:0] << off_i;
        wdata_o = wdata_i << {off_i, 3'b000};

        shifted = rdata_i >> {off_i, 3'b000};
        load_o  = shifted;
        case (size_i)
            SZ_B: begin
                if (sext_i) load_o = DATA_W'($signed(shifted[7:0]));
                else        load_o = DATA_W'(shifted[7:0]);
            end
            SZ_H: begin
                if (sext_i) load_o = DATA_W'($signed(shifted[15:0]));
                else        load_o = DATA_W'(shifted[15:0]);
            end
            SZ_W: begin
                if (sext_i) load_o = DATA_W'($signed(shifted[31:0]));
                else        load_o = DATA_W'(shifted[31:0]);
            end
            default: load_o = shifted;
        endcase
    end

endmodule

// File: rtl/ysyx_25010008_lsu_axi.sv
// Load/store unit: accepts one core request at a time and runs it over AXI read or write channels.
module ysyx_25010008_lsu_axi
    import ysyx_25010008_lsu_pkg::*;
#(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_wen,
    input  logic [1:0]            req_size,
    input  logic                  req_sext,
    input  logic [ADDR_W-1:0]     req_addr,
    input  logic [DATA_W-1:0]     req_wdata,
    output logic                  done,
    output logic [DATA_W-1:0]     rdata,
    output logic [1:0]            err,
    ysyx_25010008_lsu_axi_if.master axi
);

    localparam int unsigned STRB_W = DATA_W / 8;
    localparam int unsigned OFF_W  = $clog2(STRB_W);
    localparam int unsigned CNT_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    lsu_state_e          state_q, state_d;
    lsu_err_e            err_q, err_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [1:0]          size_q, size_d;
    logic                sext_q, sext_d;
    logic                wen_q, wen_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic                arvalid_q, arvalid_d;
    logic                awvalid_q, awvalid_d;
    logic                wvalid_q, wvalid_d;
    logic                rready_q, rready_d;
    logic                bready_q, bready_d;
    logic                done_q, done_d;
    logic                req_ready_q, req_ready_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic [CNT_W-1:0]    wait_q, wait_d;

    logic                timeout_hit;
    logic                expire;
    logic [STRB_W-1:0]   wstrb_al;
    logic [DATA_W-1:0]   wdata_al;
    logic [DATA_W-1:0]   load_data;

    ysyx_25010008_lsu_align #(
        .DATA_W (DATA_W)
    ) u_align (
        .off_i   (addr_q[OFF_W-1:0]),
        .size_i  (size_q),
        .sext_i  (sext_q),
        .wdata_i (wdata_q),
        .rdata_i (axi.rdata_bus),
        .wstrb_o (wstrb_al),
        .wdata_o (wdata_al),
        .load_o  (load_data)
    );

    always_comb begin
        state_d   = state_q;
        err_d     = err_q;
        addr_d    = addr_q;
        size_d    = size_q;
        sext_d    = sext_q;
        wen_d     = wen_q;
        wdata_d   = wdata_q;
        arvalid_d = arvalid_q;
        awvalid_d = awvalid_q;
        wvalid_d  = wvalid_q;
        rready_d  = rready_q;
        bready_d  = bready_q;
        rdata_d   = rdata_q;
        done_d    = 1'b0;
        expire    = 1'b0;

        timeout_hit = (TIMEOUT != 0) && (wait_q == CNT_W'(TIMEOUT - 1));

        case (state_q)
            S_IDLE: begin
                if (req_valid && req_ready_q) begin
                    addr_d  = req_addr;
                    size_d  = req_size;
                    sext_d  = req_sext;
                    wen_d   = req_wen;
                    wdata_d = req_wdata;
                    if (is_misaligned(req_addr[2:0], req_size, DATA_W == 64)) begin
                        state_d = S_DONE;
                        err_d   = ERR_MISALIGN;
                        rdata_d = '0;
                        done_d  = 1'b1;
                    end else if (req_wen) begin
                        state_d   = S_WRITE;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                    end else begin
                        state_d   = S_RADDR;
                        arvalid_d = 1'b1;
                    end
                end
            end
            S_RADDR: begin
                if (axi.arready) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = S_RDATA;
                end else begin
                    expire = timeout_hit;
                end
            end
            S_RDATA: begin
                if (axi.rvalid) begin
                    rready_d = 1'b0;
                    state_d  = S_DONE;
                    done_d   = 1'b1;
                    if (axi.rresp != 2'b00) begin
                        err_d   = ERR_BUS;
                        rdata_d = '0;
                    end else begin
                        err_d   = ERR_OK;
                        rdata_d = wen_q ? '0 : load_data;
                    end
                end else begin
                    expire = timeout_hit;
                end
            end
            S_WRITE: begin
                // Address and data channels retire independently; leave once both have.
                awvalid_d = awvalid_q && !axi.awready;
                wvalid_d  = wvalid_q && !axi.wready;
                if (!awvalid_d && !wvalid_d) begin
                    bready_d = 1'b1;
                    state_d  = S_BRESP;
                end else begin
                    expire = timeout_hit;
                end
            end
            S_BRESP: begin
                if (axi.bvalid) begin
                    bready_d = 1'b0;
                    state_d  = S_DONE;
                    done_d   = 1'b1;
                    rdata_d  = '0;
                    err_d    = (axi.bresp != 2'b00) ? ERR_BUS : ERR_OK;
                end else begin
                    expire = timeout_hit;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        if (expire) begin
            arvalid_d = 1'b0;
            awvalid_d = 1'b0;
            wvalid_d  = 1'b0;
            rready_d  = 1'b0;
            bready_d  = 1'b0;
            state_d   = S_DONE;
            err_d     = ERR_TIMEOUT;
            rdata_d   = '0;
            done_d    = 1'b1;
        end

        req_ready_d = (state_d == S_IDLE);
        wait_d      = (state_d != state_q) ? '0 : wait_q + CNT_W'(1);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            err_q       <= ERR_OK;
            addr_q      <= '0;
            size_q      <= '0;
            sext_q      <= 1'b0;
            wen_q       <= 1'b0;
            wdata_q     <= '0;
            arvalid_q   <= 1'b0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            rready_q    <= 1'b0;
            bready_q    <= 1'b0;
            done_q      <= 1'b0;
            req_ready_q <= 1'b0;
            rdata_q     <= '0;
            wait_q      <= '0;
        end else begin
            state_q     <= state_d;
            err_q       <= err_d;
            addr_q      <= addr_d;
            size_q      <= size_d;
            sext_q      <= sext_d;
            wen_q       <= wen_d;
            wdata_q     <= wdata_d;
            arvalid_q   <= arvalid_d;
            awvalid_q   <= awvalid_d;
            wvalid_q    <= wvalid_d;
            rready_q    <= rready_d;
            bready_q    <= bready_d;
            done_q      <= done_d;
            req_ready_q <= req_ready_d;
            rdata_q     <= rdata_d;
            wait_q      <= wait_d;
        end
    end

    assign req_ready   = req_ready_q;
    assign done        = done_q;
    assign rdata       = rdata_q;
    assign err         = err_q;

    assign axi.arvalid = arvalid_q;
    assign axi.araddr  = addr_q;
    assign axi.rready  = rready_q;
    assign axi.awvalid = awvalid_q;
    assign axi.awaddr  = addr_q;
    assign axi.wvalid  = wvalid_q;
    assign axi.wdata   = wdata_al;
    assign axi.wstrb   = wstrb_al;
    assign axi.bready  = bready_q;

endmodule

// File: tb/tb_ysyx_25010008_lsu_axi.sv
// Directed bench for the LSU AXI master: 32-bit instance (TIMEOUT 8) and 64-bit instance.
module tb_ysyx_25010008_lsu_axi;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    logic        req_valid, req_ready, req_wen, req_sext, done;
    logic [1:0]  req_size, err;
    logic [31:0] req_addr, req_wdata, rdata;

    logic        w_req_valid, w_req_ready, w_req_wen, w_req_sext, w_done;
    logic [1:0]  w_req_size, w_err;
    logic [31:0] w_req_addr;
    logic [63:0] w_req_wdata, w_rdata;

    ysyx_25010008_lsu_axi_if #(.ADDR_W(32), .DATA_W(32)) bus32 ();
    ysyx_25010008_lsu_axi_if #(.ADDR_W(32), .DATA_W(64)) bus64 ();

    ysyx_25010008_lsu_axi #(.DATA_W(32), .ADDR_W(32), .TIMEOUT(8)) dut32 (
        .clock     (clock),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_wen   (req_wen),
        .req_size  (req_size),
        .req_sext  (req_sext),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .done      (done),
        .rdata     (rdata),
        .err       (err),
        .axi       (bus32)
    );

    ysyx_25010008_lsu_axi #(.DATA_W(64), .ADDR_W(32)) dut64 (
        .clock     (clock),
        .reset     (reset),
        .req_valid (w_req_valid),
        .req_ready (w_req_ready),
        .req_wen   (w_req_wen),
        .req_size  (w_req_size),
        .req_sext  (w_req_sext),
        .req_addr  (w_req_addr),
        .req_wdata (w_req_wdata),
        .done      (w_done),
        .rdata     (w_rdata),
        .err       (w_err),
        .axi       (bus64)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clock);
    endtask

    task automatic run_load32(input string tag, input logic [31:0] addr, input logic [1:0] size,
                              input logic sext, input logic [31:0] bus, input logic [31:0] exp);
        bus32.arready   = 1'b1;
        bus32.rvalid    = 1'b1;
        bus32.rresp     = 2'b00;
        bus32.rdata_bus = bus;
        req_valid = 1'b1; req_wen = 1'b0; req_size = size; req_sext = sext; req_addr = addr;
        step();
        req_valid = 1'b0;
        chk({tag, "_araddr"}, bus32.araddr, addr);
        step();
        chk({tag, "_rready"}, bus32.rready, 1'b1);
        step();
        chk({tag, "_done"}, done, 1'b1);
        chk({tag, "_rdata"}, rdata, exp);
        chk({tag, "_err"}, err, 2'd0);
        step();
        chk({tag, "_done_pulse"}, done, 1'b0);
        bus32.arready = 1'b0;
        bus32.rvalid  = 1'b0;
    endtask

    initial begin
        reset = 1'b0;
        req_valid = 1'b0; req_wen = 1'b0; req_size = 2'd0; req_sext = 1'b0;
        req_addr = '0; req_wdata = '0;
        w_req_valid = 1'b0; w_req_wen = 1'b0; w_req_size = 2'd0; w_req_sext = 1'b0;
        w_req_addr = '0; w_req_wdata = '0;
        bus32.arready = 1'b0; bus32.rvalid = 1'b0; bus32.rdata_bus = '0; bus32.rresp = 2'b00;
        bus32.awready = 1'b0; bus32.wready = 1'b0; bus32.bvalid = 1'b0; bus32.bresp = 2'b00;
        bus64.arready = 1'b0; bus64.rvalid = 1'b0; bus64.rdata_bus = '0; bus64.rresp = 2'b00;
        bus64.awready = 1'b0; bus64.wready = 1'b0; bus64.bvalid = 1'b0; bus64.bresp = 2'b00;

        // Reset state
        step();
        chk("rst_req_ready", req_ready, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_err", err, 2'd0);
        chk("rst_rdata", rdata, 32'h0);
        chk("rst_arvalid", bus32.arvalid, 1'b0);
        chk("rst_awvalid", bus32.awvalid, 1'b0);
        chk("rst_wvalid", bus32.wvalid, 1'b0);
        chk("rst_rready", bus32.rready, 1'b0);
        chk("rst_bready", bus32.bready, 1'b0);
        reset = 1'b1;
        step();
        chk("post_rst_ready32", req_ready, 1'b1);
        chk("post_rst_ready64", w_req_ready, 1'b1);

        // Misaligned word load; a req_valid held through DONE waits for IDLE
        req_valid = 1'b1; req_wen = 1'b0; req_size = 2'd2; req_sext = 1'b0; req_addr = 32'h8000_0001;
        step();
        chk("mis_done", done, 1'b1);
        chk("mis_err", err, 2'd2);
        chk("mis_arvalid", bus32.arvalid, 1'b0);
        chk("mis_ready_in_done", req_ready, 1'b0);
        step();
        chk("mis_idle_done", done, 1'b0);
        chk("mis_idle_ready", req_ready, 1'b1);
        chk("mis_idle_arvalid", bus32.arvalid, 1'b0);
        step();
        chk("mis_again_done", done, 1'b1);
        chk("mis_again_err", err, 2'd2);
        req_valid = 1'b0;
        step();
        chk("mis_pulse", done, 1'b0);

        // Signed byte load, zero-wait slave: done in the fourth cycle counting acceptance
        bus32.arready = 1'b1; bus32.rvalid = 1'b1; bus32.rresp = 2'b00; bus32.rdata_bus = 32'h80AB_CDEF;
        req_valid = 1'b1; req_wen = 1'b0; req_size = 2'd0; req_sext = 1'b1; req_addr = 32'h8000_0003;
        step();
        req_valid = 1'b0;
        chk("lb_arvalid", bus32.arvalid, 1'b1);
        chk("lb_araddr", bus32.araddr, 32'h8000_0003);
        chk("lb_busy", req_ready, 1'b0);
        chk("lb_c2_done", done, 1'b0);
        step();
        chk("lb_rready", bus32.rready, 1'b1);
        chk("lb_ar_drop", bus32.arvalid, 1'b0);
        chk("lb_c3_done", done, 1'b0);
        step();
        chk("lb_done", done, 1'b1);
        chk("lb_rdata", rdata, 32'hFFFF_FF80);
        chk("lb_err", err, 2'd0);
        chk("lb_rready_drop", bus32.rready, 1'b0);
        step();
        chk("lb_pulse", done, 1'b0);
        chk("lb_ready", req_ready, 1'b1);
        bus32.arready = 1'b0; bus32.rvalid = 1'b0;

        // Halfword store: aw handshake in cycle 2, w handshake in cycle 5
        bus32.awready = 1'b1; bus32.wready = 1'b0; bus32.bvalid = 1'b0; bus32.bresp = 2'b00;
        req_valid = 1'b1; req_wen = 1'b1; req_size = 2'd1; req_sext = 1'b0;
        req_addr = 32'h8000_0002; req_wdata = 32'h0000_1234;
        step();
        req_valid = 1'b0;
        chk("sh_awvalid", bus32.awvalid, 1'b1);
        chk("sh_wvalid", bus32.wvalid, 1'b1);
        chk("sh_wstrb", bus32.wstrb, 4'b1100);
        chk("sh_wdata", bus32.wdata, 32'h1234_0000);
        chk("sh_awaddr", bus32.awaddr, 32'h8000_0002);
        step();
        bus32.awready = 1'b0;
        chk("sh_aw_drop", bus32.awvalid, 1'b0);
        chk("sh_w_hold", bus32.wvalid, 1'b1);
        step();
        chk("sh_w_hold4", bus32.wvalid, 1'b1);
        chk("sh_wdata_hold", bus32.wdata, 32'h1234_0000);
        step();
        chk("sh_w_hold5", bus32.wvalid, 1'b1);
        chk("sh_no_bready", bus32.bready, 1'b0);
        bus32.wready = 1'b1;
        step();
        bus32.wready = 1'b0;
        chk("sh_w_drop", bus32.wvalid, 1'b0);
        chk("sh_bready", bus32.bready, 1'b1);
        chk("sh_no_done", done, 1'b0);
        bus32.bvalid = 1'b1;
        step();
        bus32.bvalid = 1'b0;
        chk("sh_done", done, 1'b1);
        chk("sh_err", err, 2'd0);
        chk("sh_rdata_zero", rdata, 32'h0);
        chk("sh_bready_drop", bus32.bready, 1'b0);
        step();
        chk("sh_pulse", done, 1'b0);

        // Aligned word load so rdata is nonzero before the timeout case
        run_load32("lw", 32'h8000_0008, 2'd2, 1'b1, 32'h1357_9BDF, 32'h1357_9BDF);

        // Timeout: arready never comes, arvalid held for exactly 8 cycles
        req_valid = 1'b1; req_wen = 1'b0; req_size = 2'd2; req_sext = 1'b0; req_addr = 32'h8000_0004;
        step();
        req_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("to_arvalid_%0d", i), bus32.arvalid, 1'b1);
            chk($sformatf("to_araddr_%0d", i), bus32.araddr, 32'h8000_0004);
            step();
        end
        chk("to_ar_drop", bus32.arvalid, 1'b0);
        chk("to_done", done, 1'b1);
        chk("to_err", err, 2'd3);
        chk("to_rdata", rdata, 32'h0);
        step();
        chk("to_pulse", done, 1'b0);

        // 64-bit: unsigned halfword from the top lanes, then doubleword with SLVERR
        bus64.arready = 1'b1; bus64.rvalid = 1'b1; bus64.rresp = 2'b00;
        bus64.rdata_bus = 64'h1122_3344_5566_7788;
        w_req_valid = 1'b1; w_req_wen = 1'b0; w_req_size = 2'd1; w_req_sext = 1'b0; w_req_addr = 32'h8000_0006;
        step();
        w_req_valid = 1'b0;
        step();
        step();
        chk("w_lh_done", w_done, 1'b1);
        chk("w_lh_rdata", w_rdata, 64'h0000_0000_0000_1122);
        chk("w_lh_err", w_err, 2'd0);
        step();
        bus64.rresp = 2'b10;
        w_req_valid = 1'b1; w_req_size = 2'd3; w_req_addr = 32'h8000_0008;
        step();
        w_req_valid = 1'b0;
        chk("w_ld_arvalid", bus64.arvalid, 1'b1);
        chk("w_ld_araddr", bus64.araddr, 32'h8000_0008);
        step();
        step();
        chk("w_ld_done", w_done, 1'b1);
        chk("w_ld_err", w_err, 2'd1);
        chk("w_ld_rdata", w_rdata, 64'h0);
        step();
        bus64.arready = 1'b0; bus64.rvalid = 1'b0; bus64.rresp = 2'b00;

        // Reset asserted mid-transaction in BRESP
        bus32.awready = 1'b1; bus32.wready = 1'b1; bus32.bvalid = 1'b0;
        req_valid = 1'b1; req_wen = 1'b1; req_size = 2'd2; req_addr = 32'h8000_0010; req_wdata = 32'hCAFE_F00D;
        step();
        req_valid = 1'b0;
        chk("sw_wstrb", bus32.wstrb, 4'hF);
        chk("sw_wdata", bus32.wdata, 32'hCAFE_F00D);
        step();
        chk("sw_bready", bus32.bready, 1'b1);
        #1 reset = 1'b0;
        #1;
        chk("ar_bready", bus32.bready, 1'b0);
        chk("ar_awvalid", bus32.awvalid, 1'b0);
        chk("ar_wvalid", bus32.wvalid, 1'b0);
        chk("ar_arvalid", bus32.arvalid, 1'b0);
        chk("ar_rready", bus32.rready, 1'b0);
        chk("ar_done", done, 1'b0);
        chk("ar_req_ready", req_ready, 1'b0);
        chk("ar_err", err, 2'd0);
        chk("ar_rdata", rdata, 32'h0);
        bus32.awready = 1'b0; bus32.wready = 1'b0; bus32.bvalid = 1'b1;
        step();
        reset = 1'b1;
        step();
        chk("rel_req_ready", req_ready, 1'b1);
        chk("rel_no_resume_done", done, 1'b0);
        chk("rel_no_resume_bready", bus32.bready, 1'b0);
        bus32.bvalid = 1'b0;
        run_load32("post", 32'h8000_0020, 2'd2, 1'b0, 32'hDEAD_BEEF, 32'hDEAD_BEEF);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ysyx_25010008_lsu_axi.md
YSYX_25010008_LSU_AXI -- requirements
Module: ysyx_25010008_lsu_axi

Interface
REQ-001 Clock/reset SHALL be: one clock; reset is asynchronous and active-low. Ports are named clock and reset, with reset asserted at 0.
REQ-002 Parameters SHALL be:
- DATA_W, default 32, bus data width; legal values 32 and 64.
- ADDR_W, default 32, address width.
- TIMEOUT, default 255, maximum cycles spent waiting in any bus state; 0 disables the timeout.
REQ-003 Ports SHALL be (name, direction, width, meaning):
- clock in 1, clock.
- reset in 1, asynchronous active-low reset.
- req_valid in 1, core request.
- req_ready out 1, request accepted.
- req_wen in 1, 1 = store, 0 = load.
- req_size in 2, 0 = B, 1 = H, 2 = W, 3 = D.
- req_sext in 1, sign-extend load data.
- req_addr in ADDR_W, byte address.
- req_wdata in DATA_W, store data, LSB-aligned.
- done out 1, one-cycle completion pulse.
- rdata out DATA_W, load result.
- err out 2, 0 = ok, 1 = bus error, 2 = misaligned, 3 = timeout.
- AXI read channels: arvalid out 1, arready in 1, araddr out ADDR_W, rvalid in 1, rready out 1, rdata_bus in DATA_W, rresp in 2.
- AXI write channels: awvalid out 1, awready in 1, awaddr out ADDR_W, wvalid out 1, wready in 1, wdata out DATA_W, wstrb out DATA_W/8, bvalid in 1, bready out 1, bresp in 2.

Function
REQ-004 req_ready SHALL be 1 only in state IDLE; a request is accepted on a cycle where req_valid && req_ready. req_addr, req_size, req_sext, req_wen and req_wdata SHALL be latched on acceptance.
REQ-005 States SHALL be IDLE, RADDR, RDATA, WRITE, BRESP, DONE.
REQ-006 A request SHALL be misaligned if the address is not a multiple of 2^size, or if size = 3 with DATA_W = 32. A misaligned request SHALL go IDLE -> DONE with err = 2 and no bus valid asserted.
REQ-007 An aligned load SHALL go IDLE -> RADDR, asserting arvalid and driving araddr = latched addr. On arready it SHALL go to RDATA with rready = 1. On rvalid it SHALL capture rdata and set err = 1 if rresp != 0, then go to DONE.
REQ-008 An aligned store SHALL go IDLE -> WRITE, asserting awvalid and wvalid together. Each valid SHALL drop independently on its own ready. Once both handshakes are complete, the FSM SHALL go to BRESP with bready = 1. On bvalid it SHALL set err = 1 if bresp != 0, then go to DONE.
REQ-009 In DONE, done SHALL be 1 for exactly one cycle, with rdata and err valid in that cycle; the next state SHALL be IDLE. Minimum latency for an aligned request is 4 cycles from acceptance to done.
REQ-010 Lane alignment SHALL use off = addr[log2(DATA_W/8)-1:0]:
- wstrb = ((1 << 2^size) - 1) << off.
- wdata = req_wdata << (8*off).
- Load data = rdata_bus >> (8*off), truncated to 2^size bytes, then sign- or zero-extended to DATA_W per req_sext.
REQ-011 A per-state wait counter SHALL clear on every state change. If TIMEOUT != 0 and the counter reaches TIMEOUT in RADDR, RDATA, WRITE or BRESP, the FSM SHALL drop all valids and readies, set err = 3 and go to DONE.
REQ-012 rdata SHALL be 0 on store completion and on any error completion.
REQ-013 arvalid, awvalid and wvalid SHALL hold stable, with their address and data unchanged, until their handshake completes or a timeout occurs.
REQ-014 rready SHALL be 1 only in RDATA, and bready only in BRESP.
REQ-015 A req_valid arriving during DONE SHALL be accepted no earlier than the following IDLE cycle.

Reset
REQ-016 While reset = 0, all of the following SHALL be 0 asynchronously, including mid-transaction: arvalid, awvalid, wvalid, rready, bready, done, req_ready, err, rdata, wait counter. The state SHALL be IDLE.
REQ-017 After reset deasserts, req_ready SHALL be 1 on the first clock edge; no in-flight transaction is resumed.

Structure
REQ-018 Package ysyx_25010008_lsu_pkg SHALL hold the state enum, the size encodings and the err codes.
REQ-019 Sub-module ysyx_25010008_lsu_align (combinational) SHALL implement the wstrb, wdata and load shift/extend logic of REQ-010.

Verification
REQ-020 The bench SHALL cover these directed scenarios (DATA_W = 32 unless stated):
- Load B, sext = 1, addr 0x8000_0003, rdata_bus 0x80xx_xxxx, zero-wait slave -> done at cycle 4, rdata 0xFFFF_FF80, err 0.
- Store H, addr 0x8000_0002, wdata 0x1234 -> wstrb 0b1100, wdata 0x1234_0000; awvalid/wvalid handshakes in cycles 2/5 respectively; done after bvalid.
- Load W, addr 0x8000_0001 -> done next cycle, err 2, arvalid never asserted.
- TIMEOUT = 8, arready held 0 -> arvalid drops after 8 cycles, done with err 3, rdata 0.
- DATA_W = 64, load D, addr 0x8000_0008, rresp = 2 -> err 1, rdata 0.
- reset = 0 asserted while in BRESP -> all valids, readies and done are 0 within the same cycle; the next request after release completes normally.
